// File: rtl/seven_segment_capture_if.sv
// Scanned seven-segment bus as seen by the capture block, plus the rebuilt frame it publishes.
interface seven_segment_capture_if #(
    parameter int unsigned w_digit = 4
);
    logic [7:0]           abcdefgh;
    logic [w_digit-1:0]   digit;
    logic [w_digit*4-1:0] number;
    logic [w_digit-1:0]   dots;
    logic                 valid;
    logic                 seg_err;

    // Bus driver / frame consumer side
    modport master (
        output abcdefgh,
        output digit,
        input  number,
        input  dots,
        input  valid,
        input  seg_err
    );

    // Capture block side
    modport slave (
        input  abcdefgh,
        input  digit,
        output number,
        output dots,
        output valid,
        output seg_err
    );
endinterface

// File: rtl/seven_segment_capture.sv
// Rebuilds a hex number and dot pattern from a multiplexed abcdefgh/digit display bus.
module seven_segment_capture #(
    parameter int unsigned w_digit       = 4,
    parameter int unsigned stable_cycles = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_segment_capture_if.slave bus
);

    localparam int unsigned STAB_W = $clog2(stable_cycles + 1);
    localparam int unsigned IDX_W  = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam int unsigned NUM_W  = w_digit * 4;
    localparam int unsigned PAIR_W = w_digit + 8;

    logic [7:0]         seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [w_digit-1:0] dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d;
    logic [PAIR_W-1:0]  pair_prev_q, pair_prev_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic [NUM_W-1:0]   shadow_num_q, shadow_num_d;
    logic [w_digit-1:0] shadow_dot_q, shadow_dot_d;
    logic [w_digit-1:0] shadow_bad_q, shadow_bad_d;
    logic [w_digit-1:0] seen_q, seen_d;
    logic [NUM_W-1:0]   number_q, number_d;
    logic [w_digit-1:0] dots_q, dots_d;
    logic               valid_q, valid_d;
    logic               seg_err_q, seg_err_d;

    logic               same_c;
    logic               one_hot_c;
    logic               capture_c;
    logic [IDX_W-1:0]   cap_idx_c;
    logic [3:0]         nibble_c;
    logic               bad_c;

    // Two-flop synchronizers and previous-cycle copy of the synchronized pair
    always_comb begin
        seg_s1_d    = bus.abcdefgh;
        seg_s2_d    = seg_s1_q;
        dig_s1_d    = bus.digit;
        dig_s2_d    = dig_s1_q;
        pair_prev_d = {dig_s2_q, seg_s2_q};
    end

    // Stability counter: restarts on any change, saturates at stable_cycles
    always_comb begin
        same_c = ({dig_s2_q, seg_s2_q} == pair_prev_q);
        stab_d = stab_q;
        if (!same_c) begin
            stab_d = '0;
        end else if (stab_q != STAB_W'(stable_cycles)) begin
            stab_d = stab_q + STAB_W'(1);
        end
    end

    // Digit select qualification and slot index of the one-hot bit
    always_comb begin
        one_hot_c = (dig_s2_q != '0) && ((dig_s2_q & (dig_s2_q - w_digit'(1))) == '0);
        cap_idx_c = '0;
        for (int unsigned i = 0; i < w_digit; i++) begin
            if (dig_s2_q[i]) begin
                cap_idx_c = IDX_W'(i);
            end
        end
        capture_c = same_c && one_hot_c && (stab_q == STAB_W'(stable_cycles - 1));
    end

    // Segment pattern a..g back to a nibble; anything off-table is flagged
    always_comb begin
        nibble_c = 4'h0;
        bad_c    = 1'b0;
        case (seg_s2_q[7:1])
            7'b1111110: nibble_c = 4'h0;
            7'b0110000: nibble_c = 4'h1;
            7'b1101101: nibble_c = 4'h2;
            7'b1111001: nibble_c = 4'h3;
            7'b0110011: nibble_c = 4'h4;
            7'b1011011: nibble_c = 4'h5;
            7'b1011111: nibble_c = 4'h6;
            7'b1110000: nibble_c = 4'h7;
            7'b1111111: nibble_c = 4'h8;
            7'b1110011: nibble_c = 4'h9;
            7'b1110111: nibble_c = 4'hA;
            7'b0011111: nibble_c = 4'hB;
            7'b1001110: nibble_c = 4'hC;
            7'b0111101: nibble_c = 4'hD;
            7'b1001111: nibble_c = 4'hE;
            7'b1000111: nibble_c = 4'hF;
            default: begin
                nibble_c = 4'h0;
                bad_c    = 1'b1;
            end
        endcase
    end

    // Shadow slot update and frame commit once every position has been seen
    always_comb begin
        shadow_num_d = shadow_num_q;
        shadow_dot_d = shadow_dot_q;
        shadow_bad_d = shadow_bad_q;
        seen_d       = seen_q;
        number_d     = number_q;
        dots_d       = dots_q;
        seg_err_d    = seg_err_q;
        valid_d      = 1'b0;
        if (capture_c) begin
            shadow_num_d[{cap_idx_c, 2'b00} +: 4] = nibble_c;
            shadow_dot_d[cap_idx_c]               = seg_s2_q[0];
            shadow_bad_d[cap_idx_c]               = bad_c;
            seen_d                                = seen_q | dig_s2_q;
            if (&seen_d) begin
                number_d     = shadow_num_d;
                dots_d       = shadow_dot_d;
                seg_err_d    = |shadow_bad_d;
                valid_d      = 1'b1;
                seen_d       = '0;
                shadow_bad_d = '0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q     <= '0;
            seg_s2_q     <= '0;
            dig_s1_q     <= '0;
            dig_s2_q     <= '0;
            pair_prev_q  <= '0;
            stab_q       <= '0;
            shadow_num_q <= '0;
            shadow_dot_q <= '0;
            shadow_bad_q <= '0;
            seen_q       <= '0;
            number_q     <= '0;
            dots_q       <= '0;
            valid_q      <= 1'b0;
            seg_err_q    <= 1'b0;
        end else begin
            seg_s1_q     <= seg_s1_d;
            seg_s2_q     <= seg_s2_d;
            dig_s1_q     <= dig_s1_d;
            dig_s2_q     <= dig_s2_d;
            pair_prev_q  <= pair_prev_d;
            stab_q       <= stab_d;
            shadow_num_q <= shadow_num_d;
            shadow_dot_q <= shadow_dot_d;
            shadow_bad_q <= shadow_bad_d;
            seen_q       <= seen_d;
            number_q     <= number_d;
            dots_q       <= dots_d;
            valid_q      <= valid_d;
            seg_err_q    <= seg_err_d;
        end
    end

    assign bus.number  = number_q;
    assign bus.dots    = dots_q;
    assign bus.valid   = valid_q;
    assign bus.seg_err = seg_err_q;

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment driver: watches a scanned abcdefgh/digit bus and rebuilds the displayed hex number and dot pattern.
- Used in loopback self-test and bench monitors, and for observing third-party display buses on FPGA boards.
- Filters scan glitches, decodes each digit's segment pattern back to a nibble, and publishes a complete frame once every digit position has been seen.

Parameters:
- w_digit, 4, number of multiplexed digit positions (>= 2).
- stable_cycles, 16, consecutive clk cycles a {digit, abcdefgh} pair must hold before it is captured (>= 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset. Asynchronous, active-low: asserting it clears all state immediately, with no clock needed.
- abcdefgh  input  8  segment bus, active-high. Bit 7 = a … bit 1 = g, bit 0 = h (dot).
- digit  input  w_digit  digit select, active-high, expected one-hot.
- number  output  w_digit*4  last completed frame; nibble i belongs to digit bit i.
- dots  output  w_digit  last completed frame's dot bits; bit i = h seen with digit bit i.
- valid  output  1  one-cycle pulse: number/dots/seg_err just updated.
- seg_err  output  1  completed frame contained at least one undecodable pattern.

Behaviour:
- Reset values:
  - number, dots, valid, seg_err = 0.
  - Synchronizers, stable counter, shadow registers and seen mask = 0.
- Input path:
  - abcdefgh and digit each pass through a 2-flop synchronizer.
  - All following logic uses the synchronized values.
- Stability filter:
  - Counter `stab` is saturating; its width is $clog2(stable_cycles+1).
  - If the synchronized {digit, abcdefgh} differs from its previous-cycle value, stab <= 0. Otherwise stab increments, saturating at stable_cycles.
- Capture event:
  - Fires exactly once per stable episode: the cycle stab transitions stable_cycles-1 -> stable_cycles, and digit is one-hot.
  - digit = 0 or multi-hot never captures and produces no error.
- Decode (a..g -> nibble), exact inverse of the driver table:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7
  - 1111111=8, 1110011=9, 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F
  - Any other pattern, including all-off: nibble = 0 and the per-slot bad flag is set.
- On capture at index i (position of the one-hot bit):
  - shadow_num[i] <= nibble, shadow_dot[i] <= h, shadow_bad[i] <= invalid, seen[i] <= 1.
  - Recapturing an already-seen index overwrites its slot; seen is unchanged.
- Frame commit, when a capture makes seen all-ones:
  - On that same edge, number/dots load the shadow contents, bypassing in the just-captured slot.
  - seg_err <= OR of all bad flags, including the new one.
  - seen <= 0, shadow_bad <= 0.
  - valid = 1 for exactly the following cycle; otherwise valid = 0.
- Outputs hold between commits. A partial frame never changes the outputs.
- End-to-end latency: a bus value stable from edge T captures at edge T + 2 + stable_cycles.
- Reset asserted mid-frame: the partial frame is discarded, outputs return to 0, and no valid pulse is produced.
- The input bus carries no dot polarity or blank handling beyond the above: a digit with all segments off decodes as invalid.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> number, dots, valid, seg_err read 0 before the next clk edge.
- Clean scan (w_digit=4, stable_cycles=4): hold digit=0001/F2, 0010/66, 0100/DA, 1000/FC for 20 cycles each -> a single valid pulse; number=16'h0243, dots=4'b0000, seg_err=0.
- Dots and letters: scan A (EE), b (3F), C (9D), d (7A) on digits 0..3 -> number=16'hDCBA, dots=4'b0110, seg_err=0.
- Glitch rejection: toggle abcdefgh between 60 and FC every 2 cycles (shorter than stable_cycles) on digit 0001 -> no capture. Then hold 60 -> nibble 1 captured once.
- Bad pattern and bad select: on digit 0100 hold pattern 0x02; also hold digit=0011 for 50 cycles; then complete the frame -> the 0011 period is ignored; valid pulses with nibble2=0 and seg_err=1.
- Overwrite and reset mid-frame: capture digit0=5, then digit0=7, then digits 1..3 -> number[3:0]=7. Separately, assert reset after 2 digits -> no valid pulse, and the next full scan commits normally.
